// File: rtl/e_mdu_if.sv
// Handshake and data bundle between the E-stage operand path and the multiply/divide unit.
interface e_mdu_if;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output Start, MDUOp, A, B,
    input  Busy, HI, LO, Out
  );

  modport slave (
    input  Start, MDUOp, A, B,
    output Busy, HI, LO, Out
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div into HI/LO, plus mthi/mtlo/mfhi/mflo.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      r_state;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic               w_launch;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_div_ovf;
  logic        [31:0] w_b_div;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quo_u;
  logic        [31:0] w_rem_u;
  logic        [31:0] w_res_hi;
  logic        [31:0] w_res_lo;

  assign w_launch = bus.Start && (bus.MDUOp >= OpMult) && (bus.MDUOp <= OpDivu);

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Divisor forced to 1 on zero/overflow so the dividers never trap; overflow then
  // naturally yields quotient 0x80000000, remainder 0.
  assign w_div_ovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_b_div   = ((r_b == 32'd0) || w_div_ovf) ? 32'd1 : r_b;
  assign w_quo_s   = $signed(r_a) / $signed(w_b_div);
  assign w_rem_s   = $signed(r_a) % $signed(w_b_div);
  assign w_quo_u   = r_a / w_b_div;
  assign w_rem_u   = r_a % w_b_div;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OpMult:  {w_res_hi, w_res_lo} = w_prod_s;
      OpMultu: {w_res_hi, w_res_lo} = w_prod_u;
      OpDiv: begin
        if (r_b != 32'd0) begin
          w_res_lo = w_quo_s;
          w_res_hi = w_rem_s;
        end
      end
      OpDivu: begin
        if (r_b != 32'd0) begin
          w_res_lo = w_quo_u;
          w_res_hi = w_rem_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_launch) begin
            r_op    <= bus.MDUOp;
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_cnt   <= (bus.MDUOp <= OpMultu) ? MultCnt : DivCnt;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else if (!bus.Start) begin
            if (bus.MDUOp == OpMthi) r_hi <= bus.A;
            if (bus.MDUOp == OpMtlo) r_lo <= bus.A;
          end
        end
        StRun: begin
          // Everything on the bus is ignored here; only the countdown advances.
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (bus.MDUOp)
      OpMfhi:  bus.Out = r_hi;
      OpMflo:  bus.Out = r_lo;
      default: bus.Out = 32'd0;
    endcase
  end

  assign bus.Busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the Execute stage; sits beside the E-stage ALU and takes the same forwarded operands A/B.
- Executes mult/multu/div/divu as a multi-cycle operation and holds results in architectural HI/LO registers.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- Exports Busy so the hazard unit can stall dependent MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  one-cycle pulse launching the operation given by MDUOp (codes 1-4)
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- Out  output  32  mfhi/mflo read data to the E/M register

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - HI=0, LO=0, Busy=0, counter=0, latched operands/op=0.
  - Any in-flight result is discarded.
- Idle state (Busy=0), on the clk edge:
  - Start=1 with MDUOp in 1..4: latch A, B and MDUOp; load counter with MULT_CYCLES or DIV_CYCLES; enter RUN.
  - Start=1 with any other MDUOp: no state change.
  - Start=0 and MDUOp=5 (mthi): HI<=A. MDUOp=6 (mtlo): LO<=A. Takes effect on this edge; visible next cycle.
- RUN state (Busy=1):
  - Busy is high for exactly N cycles after the Start edge (N = selected latency).
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: write HI/LO from the latched operands, clear Busy, return to Idle.
  - Example: Start sampled at edge k; Busy=1 during cycles k+1..k+N; new HI/LO visible after edge k+N.
- While Busy=1, Start, mthi and mtlo are ignored. The hazard unit guarantees none are issued; the unit must not corrupt state if they are.
- Arithmetic:
  - mult: {HI,LO} = signed A * signed B, full 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of A.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0, div or divu): full latency still runs, Busy behaves normally, HI and LO keep their prior values.
- The result is computed from the operands latched at Start. Changes on A/B during RUN have no effect.
- Out is combinational:
  - MDUOp=7: Out=HI.
  - MDUOp=8: Out=LO.
  - Otherwise: Out=0.
  - Reads during Busy return the old HI/LO. Stalling these reads is the hazard unit's job.
- Simultaneous Start plus mthi/mtlo cannot happen, since both share MDUOp.
- A new Start is accepted on the same edge Busy falls only if Busy was already 0 in that cycle; otherwise it is ignored. So back-to-back operations need at least one Idle cycle of Start sampling.
- HI, LO and Busy are all register outputs; none depend combinationally on inputs.

Test Plan:
- Reset check: assert reset mid-cycle during RUN after a mult -> Busy, HI and LO go to 0 immediately, with no clk edge needed; after release, MDUOp=7 gives Out=0.
- Signed mult latency: mult A=0xFFFFFFFE (-2), B=3, Start pulse -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MDUOp=8 gives Out=0xFFFFFFFA.
- Unsigned mult: multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed div: div A=-7 (0xFFFFFFF9), B=2 -> Busy=1 for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divu with the same operands -> LO=0x7FFFFFFC, HI=1.
- Divide by zero: mthi A=0x12345678, mtlo A=0x9ABCDEF0, then div B=0 -> Busy=1 for 10 cycles; HI/LO unchanged. Overflow case div 0x80000000 by -1 -> LO=0x80000000, HI=0.
- Ignored writes while busy: during Busy, drive mtlo A=0xDEADBEEF and a second Start -> both ignored; final LO equals the first operation's result; Busy falls after the original count.
